// File: rtl/tpu_pkg.sv
// Shared types and size helpers for the convolution TPU slice.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int unsigned calc_output_size(input int unsigned data_size,
                                                     input int unsigned num_in_channel);
        return 2 * data_size + $clog2(num_in_channel) + 1;
    endfunction

    function automatic int unsigned calc_npey(input int unsigned kernel_width);
        return kernel_width * kernel_width;
    endfunction

endpackage

// File: rtl/buffer_router.sv
// Activation buffer, raster window address generator and run-control FSM.
module buffer_router
    import tpu_pkg::*;
#(
    parameter  int unsigned dataSize      = 8,
    parameter  int unsigned kernelWidth   = 3,
    parameter  int unsigned numRegister   = 256,
    localparam int unsigned numAddrBuffer = $clog2(numRegister),
    localparam int unsigned nPEy          = calc_npey(kernelWidth)
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [numAddrBuffer-1:0]   wr_addr,
    input  logic signed [dataSize-1:0] wr_data,
    input  logic                       wr_en,
    input  logic [15:0]                cfg_ifmap_width,
    input  logic                       ctrl_start,
    output logic signed [dataSize-1:0] act [nPEy],
    output logic                       act_valid,
    output logic                       router_flag_done,
    output logic                       flag_done
);

    state_t state, state_next;
    logic [15:0] width, width_next;
    logic [15:0] oy, oy_next, ox, ox_next;
    logic [15:0] last_pos;
    logic        drain_cnt, drain_cnt_next;
    logic        rdone_next, done_next, issue;

    logic signed [dataSize-1:0] mem [numRegister];
    logic [numAddrBuffer-1:0]   rd_addr [nPEy];

    assign last_pos = width - 16'(kernelWidth);

    // Next-state: one window per RUN cycle, two DRAIN cycles to flush the MAC pipe.
    always_comb begin
        state_next     = state;
        width_next     = width;
        oy_next        = oy;
        ox_next        = ox;
        drain_cnt_next = drain_cnt;
        rdone_next     = router_flag_done;
        done_next      = flag_done;
        issue          = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (ctrl_start) begin
                    state_next = RUN;
                    width_next = cfg_ifmap_width;
                    oy_next    = '0;
                    ox_next    = '0;
                    rdone_next = 1'b0;
                    done_next  = 1'b0;
                end
            end
            RUN: begin
                if (width < 16'(kernelWidth)) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 1'b0;
                    rdone_next     = 1'b1;
                end else begin
                    issue = 1'b1;
                    if (ox == last_pos) begin
                        ox_next = '0;
                        if (oy == last_pos) begin
                            state_next     = DRAIN;
                            drain_cnt_next = 1'b0;
                            rdone_next     = 1'b1;
                        end else begin
                            oy_next = oy + 16'd1;
                        end
                    end else begin
                        ox_next = ox + 16'd1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    drain_cnt_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state            <= IDLE;
            width            <= '0;
            oy               <= '0;
            ox               <= '0;
            drain_cnt        <= 1'b0;
            router_flag_done <= 1'b0;
            flag_done        <= 1'b0;
        end else begin
            state            <= state_next;
            width            <= width_next;
            oy               <= oy_next;
            ox               <= ox_next;
            drain_cnt        <= drain_cnt_next;
            router_flag_done <= rdone_next;
            flag_done        <= done_next;
        end
    end

    // Window tap (ky,kx) sits at (oy+ky)*W + ox+kx, wrapped to the buffer depth.
    always_comb begin
        for (int ky = 0; ky < int'(kernelWidth); ky++) begin
            for (int kx = 0; kx < int'(kernelWidth); kx++) begin
                rd_addr[ky * int'(kernelWidth) + kx] = numAddrBuffer'(
                    (32'(oy) + 32'(ky)) * 32'(width) + 32'(ox) + 32'(kx));
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < int'(numRegister); i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            act_valid <= 1'b0;
            for (int i = 0; i < int'(nPEy); i++) act[i] <= '0;
        end else begin
            act_valid <= issue;
            if (issue) begin
                for (int i = 0; i < int'(nPEy); i++) act[i] <= mem[rd_addr[i]];
            end
        end
    end

endmodule

// File: rtl/tpu_system.sv
// Convolution TPU: buffer/router front end feeding an inline MAC array per output channel.
module tpu_system
    import tpu_pkg::*;
#(
    parameter  int unsigned dataSize      = 8,
    parameter  int unsigned numInChannel  = 1,
    parameter  int unsigned kernelWidth   = 3,
    parameter  int unsigned numOutChannel = 3,
    parameter  int unsigned numRegister   = 256,
    localparam int unsigned numAddrBuffer = $clog2(numRegister),
    localparam int unsigned outputSize    = calc_output_size(dataSize, numInChannel),
    localparam int unsigned nPEy          = calc_npey(kernelWidth),
    localparam int unsigned nPEx          = numOutChannel
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic signed [dataSize-1:0]   weight [nPEy][nPEx],
    output logic signed [outputSize-1:0] matrix_out [nPEx],
    input  logic [numAddrBuffer-1:0]     wr_addr,
    input  logic signed [dataSize-1:0]   wr_data,
    input  logic                         wr_en,
    input  logic [15:0]                  cfg_ifmap_width,
    input  logic                         ctrl_start,
    output logic                         flag_done
);

    localparam int unsigned ProdW = 2 * dataSize;

    logic signed [dataSize-1:0]   act [nPEy];
    logic                         act_valid;
    logic                         router_flag_done;
    logic signed [outputSize-1:0] sum [nPEx];

    buffer_router #(
        .dataSize   (dataSize),
        .kernelWidth(kernelWidth),
        .numRegister(numRegister)
    ) u_router (
        .clk             (clk),
        .nrst            (nrst),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_en           (wr_en),
        .cfg_ifmap_width (cfg_ifmap_width),
        .ctrl_start      (ctrl_start),
        .act             (act),
        .act_valid       (act_valid),
        .router_flag_done(router_flag_done),
        .flag_done       (flag_done)
    );

    // Signed dot product per output channel, wrapping at outputSize bits.
    always_comb begin : mac
        logic signed [ProdW-1:0] prod;
        prod = '0;
        for (int j = 0; j < int'(nPEx); j++) begin
            sum[j] = '0;
            for (int i = 0; i < int'(nPEy); i++) begin
                prod   = ProdW'(act[i]) * ProdW'(weight[i][j]);
                sum[j] = sum[j] + outputSize'(prod);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int j = 0; j < int'(nPEx); j++) matrix_out[j] <= '0;
        end else if (act_valid) begin
            for (int j = 0; j < int'(nPEx); j++) matrix_out[j] <= sum[j];
        end
    end

endmodule

// File: tb/tb_tpu_system.sv
// Directed self-checking bench for tpu_system: timing, arithmetic, wrap, small-width and reset cases.
module tb_tpu_system;

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 17;
    localparam int unsigned NY = 9;
    localparam int unsigned NX = 3;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic signed [DW-1:0] weight [NY][NX];
    logic signed [OW-1:0] matrix_out [NX];
    logic [7:0]           wr_addr;
    logic signed [DW-1:0] wr_data;
    logic                 wr_en;
    logic [15:0]          cfg_ifmap_width;
    logic                 ctrl_start;
    logic                 flag_done;

    int errors = 0;
    int checks = 0;

    int wtab [NY][NX] = '{'{10, -11, 12}, '{-13, 14, -15}, '{16, -17, 18},
                          '{-42, 65, 17}, '{92, -23, 41}, '{79, 11, -64},
                          '{-5, 38, 27}, '{71, -19, 8}, '{33, 54, -29}};

    always #5 clk = ~clk;

    tpu_system dut (
        .clk            (clk),
        .nrst           (nrst),
        .weight         (weight),
        .matrix_out     (matrix_out),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .cfg_ifmap_width(cfg_ifmap_width),
        .ctrl_start     (ctrl_start),
        .flag_done      (flag_done)
    );

    task automatic set_weights(input bit use_table, input int wv);
        for (int i = 0; i < int'(NY); i++)
            for (int j = 0; j < int'(NX); j++)
                weight[i][j] = use_table ? DW'(wtab[i][j]) : DW'(wv);
    endtask

    // Writes pixels 0..24; ramp gives buf[a]=a, otherwise a constant value.
    task automatic fill_buf(input bit ramp, input int val);
        for (int a = 0; a < 25; a++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_addr = 8'(a);
            wr_data = ramp ? DW'(a) : DW'(val);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Returns just after the edge that samples ctrl_start (cycle n=0).
    task automatic start_run(input logic [15:0] w);
        @(posedge clk); #1;
        cfg_ifmap_width = w;
        ctrl_start      = 1'b1;
        @(posedge clk); #1;
        ctrl_start = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        #3 nrst = 1'b0;
        #1;
        checks++;
        if (flag_done !== 1'b0) begin
            errors++; $display("FAIL reset_flag_done: got %b expected 0", flag_done);
        end
        checks++;
        if (dut.router_flag_done !== 1'b0) begin
            errors++; $display("FAIL reset_router_done: got %b expected 0", dut.router_flag_done);
        end
        for (int j = 0; j < int'(NX); j++) begin
            checks++;
            if (matrix_out[j] !== '0) begin
                errors++; $display("FAIL reset_out[%0d]: got %0d expected 0", j, matrix_out[j]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_ramp(input bit inject);
        int k, b;
        logic signed [OW-1:0] e [NX];
        set_weights(1'b1, 0);
        fill_buf(1'b1, 0);
        start_run(16'd5);
        checks++;
        if (flag_done !== 1'b0) begin
            errors++; $display("FAIL ramp_done_cleared: got %b expected 0", flag_done);
        end
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            checks++;
            if (dut.router_flag_done !== 1'(n >= 9)) begin
                errors++; $display("FAIL ramp_router_done n=%0d: got %b expected %b",
                                   n, dut.router_flag_done, n >= 9);
            end
            checks++;
            if (flag_done !== 1'(n >= 11)) begin
                errors++; $display("FAIL ramp_flag_done n=%0d: got %b expected %b",
                                   n, flag_done, n >= 11);
            end
            if (n >= 2) begin
                k = (n - 2 > 8) ? 8 : n - 2;
                b = (k / 3) * 5 + k % 3;
                e[0] = OW'(2041 + 241 * b);
                e[1] = OW'(1063 + 112 * b);
                e[2] = OW'(-86 + 15 * b);
                for (int j = 0; j < int'(NX); j++) begin
                    checks++;
                    if (matrix_out[j] !== e[j]) begin
                        errors++; $display("FAIL ramp_out[%0d] n=%0d inject=%0d: got %0d expected %0d",
                                           j, n, inject, matrix_out[j], e[j]);
                    end
                end
            end
            if (inject && n == 3) begin
                ctrl_start      = 1'b1;
                cfg_ifmap_width = 16'd7;
            end
            if (inject && n == 4) ctrl_start = 1'b0;
        end
    endtask

    task automatic test_uniform(input bit use_table, input int av, input int wv,
                                input int e0, input int e1, input int e2);
        logic signed [OW-1:0] e [NX];
        e[0] = OW'(e0); e[1] = OW'(e1); e[2] = OW'(e2);
        set_weights(use_table, wv);
        fill_buf(1'b0, av);
        start_run(16'd5);
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
            if (n >= 2) begin
                for (int j = 0; j < int'(NX); j++) begin
                    checks++;
                    if (matrix_out[j] !== e[j]) begin
                        errors++; $display("FAIL uniform_out[%0d] act=%0d n=%0d: got %0d expected %0d",
                                           j, av, n, matrix_out[j], e[j]);
                    end
                end
            end
        end
        checks++;
        if (flag_done !== 1'b1) begin
            errors++; $display("FAIL uniform_flag_done act=%0d: got %b expected 1", av, flag_done);
        end
    endtask

    task automatic test_small_width(input int held);
        start_run(16'd2);
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (dut.router_flag_done !== 1'b1) begin
            errors++; $display("FAIL small_router_done: got %b expected 1", dut.router_flag_done);
        end
        checks++;
        if (flag_done !== 1'b1) begin
            errors++; $display("FAIL small_flag_done: got %b expected 1", flag_done);
        end
        for (int j = 0; j < int'(NX); j++) begin
            checks++;
            if (matrix_out[j] !== OW'(held)) begin
                errors++; $display("FAIL small_out_held[%0d]: got %0d expected %0d", j, matrix_out[j], held);
            end
        end
    endtask

    task automatic test_reset_midrun();
        start_run(16'd5);
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (matrix_out[0] !== OW'(16384)) begin
            errors++; $display("FAIL midrun_pre_out: got %0d expected 16384", matrix_out[0]);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (flag_done !== 1'b0) begin
            errors++; $display("FAIL midrun_flag_done: got %b expected 0", flag_done);
        end
        for (int j = 0; j < int'(NX); j++) begin
            checks++;
            if (matrix_out[j] !== '0) begin
                errors++; $display("FAIL midrun_out[%0d]: got %0d expected 0", j, matrix_out[j]);
            end
        end
        @(negedge clk);
        nrst = 1'b1;
        start_run(16'd5);
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
            if (n >= 2) begin
                for (int j = 0; j < int'(NX); j++) begin
                    checks++;
                    if (matrix_out[j] !== '0) begin
                        errors++; $display("FAIL cleared_buf_out[%0d] n=%0d: got %0d expected 0",
                                           j, n, matrix_out[j]);
                    end
                end
            end
        end
        checks++;
        if (flag_done !== 1'b1) begin
            errors++; $display("FAIL cleared_buf_flag_done: got %b expected 1", flag_done);
        end
    endtask

    initial begin
        wr_en           = 1'b0;
        wr_addr         = '0;
        wr_data         = '0;
        cfg_ifmap_width = '0;
        ctrl_start      = 1'b0;
        set_weights(1'b0, 0);
        test_reset();
        test_ramp(1'b0);
        test_ramp(1'b1);
        test_uniform(1'b1, 1, 0, 241, 112, 15);
        test_uniform(1'b0, -128, -128, 16384, 16384, 16384);
        test_small_width(16384);
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tpu_system.md
TPU_SYSTEM -- requirements
Module: tpu_system

Interface
REQ-001 Parameters SHALL be: dataSize 8, activation/weight bit width; numInChannel 1, input channels; kernelWidth 3, square kernel side; numOutChannel 3, output channels; numRegister 256, activation buffer depth.
REQ-002 Derived constants SHALL be: numAddrBuffer = clog2(numRegister); outputSize = 2*dataSize + clog2(numInChannel) + 1 (17 by default); nPEy = kernelWidth^2; nPEx = numOutChannel.
REQ-003 Port clk, input, 1 bit: the single clock, rising edge.
REQ-004 Port nrst, input, 1 bit: reset; one clock; reset is asynchronous and active-low.
REQ-005 Port weight, input, unpacked [nPEy][nPEx] of dataSize bits: signed weights; row = ky*kernelWidth+kx, column = output channel.
REQ-006 Port matrix_out, output, unpacked [nPEx] of signed outputSize bits: one convolution result per output channel.
REQ-007 Port wr_addr, input, numAddrBuffer bits: activation buffer write address.
REQ-008 Port wr_data, input, dataSize bits: signed activation write data.
REQ-009 Port wr_en, input, 1 bit: write strobe.
REQ-010 Port cfg_ifmap_width, input, 16 bits: square input-map side W.
REQ-011 Port ctrl_start, input, 1 bit: start pulse.
REQ-012 Port flag_done, output, 1 bit: run complete, level.

Function
REQ-013 Buffer write SHALL occur on the rising clk edge when wr_en=1: buf[wr_addr] <= wr_data; writes are accepted in every state and are not forwarded to a same-cycle read.
REQ-014 Pixel (r,c) SHALL reside at address r*W+c, taken modulo numRegister.
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, DONE; ctrl_start=1 in IDLE or DONE latches W, clears flag_done and router_flag_done, and enters RUN; ctrl_start in RUN/DRAIN SHALL be ignored.
REQ-016 In RUN, one window per cycle SHALL be issued in raster order over output positions (oy,ox), 0..W-kernelWidth each; window k holds the nPEy activations buf[(oy+ky)*W+ox+kx].
REQ-017 After the last window, the internal top-level signal router_flag_done SHALL go high and stay high; the FSM enters DRAIN.
REQ-018 matrix_out[j] SHALL equal sum over i of act[i]*weight[i][j], signed arithmetic, truncated (wrapped) to outputSize bits.
REQ-019 Latency SHALL be 2 cycles: window issued at cycle S+k appears on matrix_out at cycle S+k+2.
REQ-020 flag_done SHALL rise the cycle after the last result appears (FSM enters DONE) and hold until the next accepted ctrl_start; matrix_out holds the last result meanwhile.
REQ-021 If W < kernelWidth, no windows SHALL be issued; router_flag_done and flag_done rise within 3 cycles of start and matrix_out is unchanged.
REQ-022 Weights SHALL be read combinationally each cycle; weight changes during RUN affect windows issued afterwards.

Reset
REQ-023 nrst=0 SHALL immediately force IDLE, flag_done=0, router_flag_done=0, matrix_out all 0, pipeline registers 0, and all buffer entries 0, including mid-run; after release the block waits for ctrl_start.

Structure
REQ-024 A shared package tpu_pkg SHALL hold the FSM state enum and the outputSize/nPEy derivation helpers.
REQ-025 The buffer, window address generation and FSM SHALL form a sub-module buffer_router; the multiply-accumulate array and output registers SHALL be inline in tpu_system.

Verification
REQ-026 Weight set rows 0..8 = (10,-11,12),(-13,14,-15),(16,-17,18),(-42,65,17),(92,-23,41),(79,11,-64),(-5,38,27),(71,-19,8),(33,54,-29); write buf[a]=a for a=0..24; W=5; start -> first outputs 2041, 1063, -86; second 2282, 1175, -71; 9 results total.
REQ-027 Same weights with all 25 activations = 1 -> every output = 241, 112, 15.
REQ-028 All activations = -128, all weights = -128 -> each output = 16384 (147456 wrapped to 17 bits).
REQ-029 Start pulse at cycle S with W=5 -> router_flag_done high from S+9; flag_done high from S+11; a second ctrl_start during RUN has no effect.
REQ-030 nrst pulsed low at window 4 -> flag_done=0 and outputs 0 at once; a new start then reads an all-zero buffer and yields outputs 0.
